soc_ctrl_pwr_seq: RTL

Parametrised successor to the per-domain clock/reset delay generator. One central FSM sequences clock enable and reset release across NUM_CH domains (cores, links, peripherals), running on the reference clock. Each domain waits for its PLL lock with a timeout, then gets a programmable delay between clock enable and reset release. Teardown runs in reverse order, and a domain that loses PLL lock while active is shut down in hardware.

---
 rtl/soc_ctrl_pwr_seq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/soc_ctrl_pwr_seq.sv
// Central power sequencer: brings NUM_CH clock/reset domains up one at a time
// (PLL lock wait, clock enable, reset release) and tears them down in reverse.
module soc_ctrl_pwr_seq #(
    parameter int NUM_CH       = 5,
    parameter int CNT_W        = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic [NUM_CH-1:0]       req_en_i,
    input  logic [NUM_CH-1:0]       lock_i,
    input  logic [NUM_CH*CNT_W-1:0] dly_i,
    input  logic [NUM_CH-1:0]       err_clr_i,
    output logic [NUM_CH-1:0]       clk_en_o,
    output logic [NUM_CH-1:0]       rst_no,
    output logic [NUM_CH-1:0]       active_o,
    output logic [NUM_CH-1:0]       err_o,
    output logic                    busy_o
);

    localparam int TO_W = $clog2(LOCK_TIMEOUT);
    localparam int CW   = (CNT_W > TO_W) ? CNT_W : TO_W;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP_LOCK,
        S_UP_CLK,
        S_UP_RST,
        S_DN_RST
    } state_t;

    // Counter load value for a phase of max(d,1) cycles.
    function automatic logic [CW-1:0] deff_m1(input logic [CNT_W-1:0] d);
        if (d == '0) begin
            return '0;
        end
        return CW'(d - 1'b1);
    endfunction

    state_t              r_state;
    logic [CH_W-1:0]     r_ch;
    logic [CW-1:0]       r_cnt;
    logic [NUM_CH-1:0]   r_clk_en;
    logic [NUM_CH-1:0]   r_rst_n;
    logic [NUM_CH-1:0]   r_active;
    logic [NUM_CH-1:0]   r_err;
    logic                r_busy;

    state_t              w_state_nxt;
    logic [CH_W-1:0]     w_ch_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [NUM_CH-1:0]   w_clk_en_nxt;
    logic [NUM_CH-1:0]   w_rst_n_nxt;
    logic [NUM_CH-1:0]   w_active_nxt;
    logic [NUM_CH-1:0]   w_err_nxt;
    logic [NUM_CH-1:0]   w_err_set;
    logic [NUM_CH-1:0]   w_up_pend;
    logic [NUM_CH-1:0]   w_dn_pend;
    logic [CH_W-1:0]     w_up_idx;
    logic [CH_W-1:0]     w_dn_idx;
    logic [CH_W-1:0]     w_sel_ch;
    logic [CNT_W-1:0]    w_dly_sel;
    logic [NUM_CH-1:0]   w_ll;

    assign w_up_pend = req_en_i & ~r_active & ~r_err & ~r_clk_en;
    assign w_dn_pend = ~req_en_i & (r_active | r_clk_en);

    // Teardown picks the highest index, bring-up the lowest.
    always_comb begin
        w_dn_idx = '0;
        w_up_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_dn_pend[i]) begin
                w_dn_idx = CH_W'(i);
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_up_pend[i]) begin
                w_up_idx = CH_W'(i);
            end
        end
    end

    assign w_sel_ch  = (r_state != S_IDLE) ? r_ch :
                       ((|w_dn_pend) ? w_dn_idx : w_up_idx);
    assign w_dly_sel = dly_i[w_sel_ch*CNT_W +: CNT_W];

    // Lock loss on a running domain; the channel being lock-waited or torn down is exempt.
    always_comb begin
        w_ll = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_ll[k] = (r_active[k] | r_clk_en[k]) & ~lock_i[k];
            if ((r_state == S_UP_LOCK || r_state == S_DN_RST) && r_ch == CH_W'(k)) begin
                w_ll[k] = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ch_nxt     = r_ch;
        w_cnt_nxt    = r_cnt;
        w_clk_en_nxt = r_clk_en;
        w_rst_n_nxt  = r_rst_n;
        w_active_nxt = r_active;
        w_err_set    = '0;

        case (r_state)
            S_IDLE: begin
                if (|w_dn_pend) begin
                    w_state_nxt            = S_DN_RST;
                    w_ch_nxt               = w_dn_idx;
                    w_rst_n_nxt[w_dn_idx]  = 1'b0;
                    w_active_nxt[w_dn_idx] = 1'b0;
                    w_cnt_nxt              = deff_m1(w_dly_sel);
                end else if (|w_up_pend) begin
                    w_state_nxt = S_UP_LOCK;
                    w_ch_nxt    = w_up_idx;
                    w_cnt_nxt   = '0;
                end
            end
            S_UP_LOCK: begin
                if (lock_i[r_ch]) begin
                    w_state_nxt        = S_UP_CLK;
                    w_clk_en_nxt[r_ch] = 1'b1;
                    w_cnt_nxt          = deff_m1(w_dly_sel);
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt     = S_IDLE;
                    w_err_set[r_ch] = 1'b1;
                end else if (!req_en_i[r_ch]) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_UP_CLK, S_UP_RST: begin
                if (w_ll[r_ch]) begin
                    w_state_nxt = S_IDLE;
                end else if (!req_en_i[r_ch]) begin
                    w_state_nxt        = S_DN_RST;
                    w_rst_n_nxt[r_ch]  = 1'b0;
                    w_active_nxt[r_ch] = 1'b0;
                    w_cnt_nxt          = deff_m1(w_dly_sel);
                end else if (r_cnt == '0) begin
                    if (r_state == S_UP_CLK) begin
                        w_state_nxt       = S_UP_RST;
                        w_rst_n_nxt[r_ch] = 1'b1;
                        w_cnt_nxt         = deff_m1(w_dly_sel);
                    end else begin
                        w_state_nxt        = S_IDLE;
                        w_active_nxt[r_ch] = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DN_RST: begin
                if (r_cnt == '0) begin
                    w_state_nxt        = S_IDLE;
                    w_clk_en_nxt[r_ch] = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Lock-loss shutdown overrides whatever the sequencer did this edge.
        w_clk_en_nxt = w_clk_en_nxt & ~w_ll;
        w_rst_n_nxt  = w_rst_n_nxt & ~w_ll;
        w_active_nxt = w_active_nxt & ~w_ll;
        w_err_nxt    = (r_err & ~err_clr_i) | w_err_set | w_ll;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state  <= S_IDLE;
            r_ch     <= '0;
            r_cnt    <= '0;
            r_clk_en <= '0;
            r_rst_n  <= '0;
            r_active <= '0;
            r_err    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ch     <= w_ch_nxt;
            r_cnt    <= w_cnt_nxt;
            r_clk_en <= w_clk_en_nxt;
            r_rst_n  <= w_rst_n_nxt;
            r_active <= w_active_nxt;
            r_err    <= w_err_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    assign clk_en_o = r_clk_en;
    assign rst_no   = r_rst_n;
    assign active_o = r_active;
    assign err_o    = r_err;
    assign busy_o   = r_busy;

endmodule
